// File: rtl/nonconsec_pulse_gen.sv
// Stimulus generator for window / repeated-pulse / qualifier traffic: opens a window,
// emits N single-cycle pulses separated by idle gaps, closes it, then strobes qual after a delay.
module nonconsec_pulse_gen #(
  parameter int CNT_W = 4,
  parameter int GAP_W = 4,
  parameter int DLY_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [GAP_W-1:0] gap,
  input  logic [DLY_W-1:0] qual_dly,
  input  logic             abort,
  output logic             busy,
  output logic             window,
  output logic             pulse,
  output logic             qual,
  output logic             done,
  output logic [2:0]       dbg_state
);

  // Handshake: start is a level sampled only in IDLE (no valid/ready pairing);
  // a launch is accepted on any edge where the FSM is idle and start is high.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_TAIL  = 3'd4,
    S_WAIT  = 3'd5,
    S_QUAL  = 3'd6
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] n_lat, n_lat_n;
  logic [GAP_W-1:0] gap_lat, gap_lat_n;
  logic [DLY_W-1:0] dly_lat, dly_lat_n;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic [DLY_W-1:0] dly_cnt, dly_cnt_n;
  logic             busy_n, window_n, pulse_n, qual_n;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      n_lat     <= '0;
      gap_lat   <= '0;
      dly_lat   <= '0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
      dly_cnt   <= '0;
      busy      <= 1'b0;
      window    <= 1'b0;
      pulse     <= 1'b0;
      qual      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      n_lat     <= n_lat_n;
      gap_lat   <= gap_lat_n;
      dly_lat   <= dly_lat_n;
      pulse_cnt <= pulse_cnt_n;
      gap_cnt   <= gap_cnt_n;
      dly_cnt   <= dly_cnt_n;
      busy      <= busy_n;
      window    <= window_n;
      pulse     <= pulse_n;
      qual      <= qual_n;
      done      <= qual_n;
    end
  end

  // The pulse counter advances on entry to PULSE, so inside PULSE it already
  // holds the number of pulses emitted including the current one.
  always_comb begin
    state_n     = state;
    n_lat_n     = n_lat;
    gap_lat_n   = gap_lat;
    dly_lat_n   = dly_lat;
    pulse_cnt_n = pulse_cnt;
    gap_cnt_n   = gap_cnt;
    dly_cnt_n   = dly_cnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          n_lat_n     = num_pulses;
          gap_lat_n   = (gap == '0) ? GAP_W'(1) : gap;
          dly_lat_n   = qual_dly;
          pulse_cnt_n = '0;
          state_n     = S_LEAD;
        end
      end
      S_LEAD: begin
        if (n_lat != '0) begin
          pulse_cnt_n = pulse_cnt + CNT_W'(1);
          state_n     = S_PULSE;
        end else begin
          state_n = S_TAIL;
        end
      end
      S_PULSE: begin
        if (pulse_cnt == n_lat) begin
          state_n = S_TAIL;
        end else begin
          gap_cnt_n = gap_lat - GAP_W'(1);
          state_n   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          pulse_cnt_n = pulse_cnt + CNT_W'(1);
          state_n     = S_PULSE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      S_TAIL: begin
        if (dly_lat == '0) begin
          state_n = S_QUAL;
        end else begin
          dly_cnt_n = dly_lat - DLY_W'(1);
          state_n   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dly_cnt == '0) state_n = S_QUAL;
        else               dly_cnt_n = dly_cnt - DLY_W'(1);
      end
      S_QUAL:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort only cancels an active sequence; in IDLE it must not block a start.
    if (abort && (state != S_IDLE)) begin
      state_n     = S_IDLE;
      pulse_cnt_n = '0;
      gap_cnt_n   = '0;
      dly_cnt_n   = '0;
    end
  end

  always_comb begin
    busy_n   = (state_n != S_IDLE);
    window_n = (state_n == S_LEAD) || (state_n == S_PULSE) ||
               (state_n == S_GAP)  || (state_n == S_TAIL);
    pulse_n  = (state_n == S_PULSE);
    qual_n   = (state_n == S_QUAL);
  end

  a_pulse_in_window: assert property (@(posedge clk) disable iff (rst) pulse |-> window);
  a_pulse_not_adj:   assert property (@(posedge clk) disable iff (rst) pulse |=> !pulse);
  a_done_with_qual:  assert property (@(posedge clk) disable iff (rst) done == qual);

endmodule

// File: doc/nonconsec_pulse_gen.md
# nonconsec_pulse_gen

Synthesizable stimulus generator for the non-consecutive-repetition protocol: on `start` it opens a qualifying window, emits a programmed number of single-cycle pulses separated by idle gaps inside that window, closes the window, and after a programmed delay issues one qualifying strobe. It drives the window/pulse/qualifier signals that the protocol's concurrent assertions consume: `$rose(window) |-> pulse[=N] ##1 ... qual`. It sits in front of those checkers in benches and in BIST-style traffic paths.

## Interface
- `CNT_W`, 4: width of pulse count; max pulses 2^CNT_W-1
- `GAP_W`, 4: width of inter-pulse gap
- `DLY_W`, 4: width of window-close to qualifier delay
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  launch request; sampled only when idle
- `num_pulses`  in  CNT_W  number of pulses N, latched on accepted start
- `gap`  in  GAP_W  idle cycles between pulses, latched; 0 treated as 1
- `qual_dly`  in  DLY_W  idle cycles between window close and qualifier, latched
- `abort`  in  1  cancel the sequence in progress
- `busy`  out  1  sequence in progress
- `window`  out  1  qualifying window (sig1 role)
- `pulse`  out  1  repeated event (sig2 role), never high two consecutive cycles
- `qual`  out  1  qualifying strobe (sig3 role), one cycle
- `done`  out  1  one-cycle completion strobe, coincident with `qual`

## Operation
- States: IDLE, LEAD, PULSE, GAP, TAIL, WAIT, QUAL. All outputs registered.
- IDLE: all outputs 0. `start`=1 latches `num_pulses`, max(`gap`,1), `qual_dly`; next state LEAD.
- LEAD (1 cycle): `window`=1, `busy`=1. Next: PULSE if N>0, else TAIL.
- PULSE (1 cycle): `window`=1, `pulse`=1, pulse counter +1. Next: TAIL if counter==N, else GAP.
- GAP (effective gap cycles): `window`=1, `pulse`=0. Then PULSE.
- TAIL (1 cycle): `window`=1, `pulse`=0. Next: QUAL if `qual_dly`==0, else WAIT.
- WAIT (`qual_dly` cycles): `window`=0, `busy`=1. Then QUAL.
- QUAL (1 cycle): `qual`=1, `done`=1, `busy`=1, `window`=0. Next IDLE.
- `start` while busy: ignored, not queued. Configuration inputs changing mid-sequence have no effect.
- `abort`=1 in any non-IDLE state: next cycle IDLE, all outputs 0, no `qual`/`done`. `abort` in IDLE is ignored. `abort` has priority over `start` in the same cycle only when not idle.
- Counters saturate-free: pulse counter is CNT_W wide and compared for equality; gap and delay counters count down from latched values.
- Guarantee: exactly N pulses while `window`=1; `pulse`=0 whenever `window`=0.

## Timing
- Reset: `busy`, `window`, `pulse`, `qual`, `done` all 0 the cycle after `rst` is sampled high; state IDLE; counters 0. Reset mid-sequence gives the same result, with no `done`.
- `start` sampled at edge t gives `window`=1 from t+1. The first pulse is at t+2. Pulse k (k=1..N) is at t+2+(k-1)(G+1), where G is the effective gap.
- TAIL is at t+2+(N-1)(G+1)+1 for N>0, or at t+2 for N=0. `window` falls after TAIL.
- `qual`/`done` occur at TAIL+1+`qual_dly`. `busy` falls the cycle after QUAL. A new `start` is accepted in that cycle, at the earliest.

## Test plan
- N=5, gap=1, dly=3, start at cycle 0 -> `window` high cycles 1–11; `pulse` at 2,4,6,8,10; `qual`=`done`=1 at 15; `busy` 1–15.
- N=5, gap=0 -> identical to gap=1; `pulse` never high on adjacent cycles.
- N=3, gap=3, dly=0 -> pulses at 2,6,10; TAIL 11; `qual` at 12.
- N=0, dly=2 -> `window` cycles 1–2; no pulse; `qual` at 5.
- N=5, gap=1, dly=3 -> `abort` at cycle 5 gives all outputs 0 from cycle 6 and no `done`; `start` at cycle 7 restarts with `window` at 8. Repeat with `rst` at cycle 5 and get the same result.
- `start` pulsed at cycle 4 during a sequence -> ignored; waveform identical to the first scenario. Bind `$rose(window) |-> pulse[=N] ##1 qual[->1]` and check it passes for all scenarios without abort/reset.
